telemetry_rx: RTL and testbench

Byte-level receiver and frame parser for the e-bike telemetry stream. It sits behind a UART receiver on the display/logging side and consumes the 8-byte frames produced by the telemetry transmitter: 0xAA, 0x55, then batt_v, avg_curr and avg_torque, each sent high byte then low byte. It validates framing, publishes the three 12-bit values atomically, and flags bad frames, byte gaps and stale data.

---
 rtl/telemetry_rx.sv | 193 +++++++++++++++++++
 tb/tb_telemetry_rx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/telemetry_rx.sv
// Byte-level parser for the 8-byte e-bike telemetry frame (AA 55 Bh Bl Ch Cl Th Tl).
// Publishes the three 12-bit readings atomically and flags framing errors, gaps and stale data.
module telemetry_rx #(
  parameter int unsigned BYTE_TO   = 65535,
  parameter int unsigned STALE_CYC = 3145728
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rdy,
  output logic [11:0] batt_v,
  output logic [11:0] avg_curr,
  output logic [11:0] avg_torque,
  output logic        frm_vld,
  output logic        frm_err,
  output logic        stale,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {
    StHunt,
    StSync2,
    StBHi,
    StBLo,
    StCHi,
    StCLo,
    StTHi,
    StTLo
  } state_e;

  localparam logic [15:0] GapLast  = 16'(BYTE_TO - 1);
  localparam logic [21:0] StaleMax = 22'(STALE_CYC);

  state_e      state_q, state_d;
  logic [3:0]  b_hi_q, b_hi_d;
  logic [7:0]  b_lo_q, b_lo_d;
  logic [3:0]  c_hi_q, c_hi_d;
  logic [7:0]  c_lo_q, c_lo_d;
  logic [3:0]  t_hi_q, t_hi_d;
  logic [15:0] gap_q, gap_d;
  logic [21:0] stale_cnt_q, stale_cnt_d;
  logic        stale_q, stale_d;
  logic [11:0] batt_q, curr_q, torq_q;
  logic        vld_q, err_q;
  logic [7:0]  err_cnt_q;
  logic        load, err, timeout;

  assign clr_rdy = rx_rdy;

  // A byte arriving on the would-be timeout edge wins, so timeout requires rx_rdy=0.
  assign timeout = (state_q != StHunt) && !rx_rdy && (gap_q == GapLast);

  always_comb begin
    state_d = state_q;
    b_hi_d  = b_hi_q;
    b_lo_d  = b_lo_q;
    c_hi_d  = c_hi_q;
    c_lo_d  = c_lo_q;
    t_hi_d  = t_hi_q;
    load    = 1'b0;
    err     = 1'b0;
    if (rx_rdy) begin
      unique case (state_q)
        StHunt: begin
          if (rx_data == 8'hAA) state_d = StSync2;
        end
        StSync2: begin
          if (rx_data == 8'h55) begin
            state_d = StBHi;
          end else if (rx_data != 8'hAA) begin
            state_d = StHunt;
            err     = 1'b1;
          end
        end
        StBHi: begin
          if (rx_data[7:4] != 4'h0) begin
            state_d = StHunt;
            err     = 1'b1;
          end else begin
            b_hi_d  = rx_data[3:0];
            state_d = StBLo;
          end
        end
        StBLo: begin
          b_lo_d  = rx_data;
          state_d = StCHi;
        end
        StCHi: begin
          if (rx_data[7:4] != 4'h0) begin
            state_d = StHunt;
            err     = 1'b1;
          end else begin
            c_hi_d  = rx_data[3:0];
            state_d = StCLo;
          end
        end
        StCLo: begin
          c_lo_d  = rx_data;
          state_d = StTHi;
        end
        StTHi: begin
          if (rx_data[7:4] != 4'h0) begin
            state_d = StHunt;
            err     = 1'b1;
          end else begin
            t_hi_d  = rx_data[3:0];
            state_d = StTLo;
          end
        end
        StTLo: begin
          load    = 1'b1;
          state_d = StHunt;
        end
        default: state_d = StHunt;
      endcase
    end else if (timeout) begin
      state_d = StHunt;
      err     = 1'b1;
    end
  end

  always_comb begin
    gap_d = gap_q + 16'd1;
    if (rx_rdy || timeout || (state_q == StHunt)) gap_d = 16'd0;
  end

  // Stale flag is its own register so it can be 1 out of reset while the counter is 0.
  always_comb begin
    stale_cnt_d = stale_cnt_q;
    stale_d     = stale_q;
    if (load) begin
      stale_cnt_d = 22'd0;
      stale_d     = 1'b0;
    end else begin
      if (stale_cnt_q != StaleMax) stale_cnt_d = stale_cnt_q + 22'd1;
      if (stale_cnt_d == StaleMax) stale_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHunt;
      b_hi_q      <= 4'h0;
      b_lo_q      <= 8'h00;
      c_hi_q      <= 4'h0;
      c_lo_q      <= 8'h00;
      t_hi_q      <= 4'h0;
      gap_q       <= 16'd0;
      stale_cnt_q <= 22'd0;
      stale_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      b_hi_q      <= b_hi_d;
      b_lo_q      <= b_lo_d;
      c_hi_q      <= c_hi_d;
      c_lo_q      <= c_lo_d;
      t_hi_q      <= t_hi_d;
      gap_q       <= gap_d;
      stale_cnt_q <= stale_cnt_d;
      stale_q     <= stale_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      batt_q    <= 12'h000;
      curr_q    <= 12'h000;
      torq_q    <= 12'h000;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      vld_q <= load;
      err_q <= err;
      if (load) begin
        batt_q <= {b_hi_q, b_lo_q};
        curr_q <= {c_hi_q, c_lo_q};
        torq_q <= {t_hi_q, rx_data};
      end
      if (err && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign batt_v     = batt_q;
  assign avg_curr   = curr_q;
  assign avg_torque = torq_q;
  assign frm_vld    = vld_q;
  assign frm_err    = err_q;
  assign stale      = stale_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_telemetry_rx.sv
// Directed bench for telemetry_rx: frames are driven byte by byte, expected readings are
// queued on the scoreboard and popped when frm_vld is seen.
module tb_telemetry_rx;

  localparam int unsigned BT = 20;
  localparam int unsigned SC = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rdy;
  logic [11:0] batt_v, avg_curr, avg_torque;
  logic        frm_vld, frm_err, stale;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad = 0;
  int err_pulses = 0;
  int vld_pulses = 0;
  int exp_err = 0;
  int exp_cnt = 0;
  int exp_frames = 0;
  logic [35:0] sb_q[$];

  telemetry_rx #(
    .BYTE_TO  (BT),
    .STALE_CYC(SC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_rdy    (rx_rdy),
    .rx_data   (rx_data),
    .clr_rdy   (clr_rdy),
    .batt_v    (batt_v),
    .avg_curr  (avg_curr),
    .avg_torque(avg_torque),
    .frm_vld   (frm_vld),
    .frm_err   (frm_err),
    .stale     (stale),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (frm_err === 1'b1) err_pulses++;
      if (frm_vld === 1'b1) begin
        vld_pulses++;
        check("frm_vld_expected", 36'(sb_q.size() != 0), 36'd1);
        if (sb_q.size() != 0) check("frame_values", {batt_v, avg_curr, avg_torque}, sb_q.pop_front());
      end
    end
  end

  // Called right after a negedge; returns on the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    rx_rdy  = 1'b1;
    rx_data = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_rdy = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_payload(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
    send_byte({4'h0, b[11:8]});
    send_byte(b[7:0]);
    send_byte({4'h0, c[11:8]});
    send_byte(c[7:0]);
    send_byte({4'h0, t[11:8]});
    sb_q.push_back({b, c, t});
    exp_frames++;
    send_byte(t[7:0]);
  endtask

  task automatic send_frame(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
    send_byte(8'hAA);
    send_byte(8'h55);
    send_payload(b, c, t);
  endtask

  task automatic expect_err(input int n);
    exp_err += n;
    exp_cnt = (exp_cnt + n > 255) ? 255 : exp_cnt + n;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_outs"}, {batt_v, avg_curr, avg_torque}, 36'h0);
    check({tag, "_vld_err"}, {34'h0, frm_vld, frm_err}, 36'h0);
    check({tag, "_stale"}, 36'(stale), 36'd1);
    check({tag, "_err_cnt"}, 36'(err_cnt), 36'd0);
    check({tag, "_clr_rdy"}, 36'(clr_rdy), 36'd0);
  endtask

  initial begin
    int hit;
    rst_n   = 1'b0;
    rx_rdy  = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // No frames yet: stale holds.
    idle(150);
    check("stale_no_frames", 36'(stale), 36'd1);

    // Clean frame from the test plan.
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h0A); send_byte(8'hBC);
    send_byte(8'h01); send_byte(8'h23); send_byte(8'h0F);
    sb_q.push_back({12'hABC, 12'h123, 12'hFFF});
    exp_frames++;
    send_byte(8'hFF);
    check("clean_vld", 36'(frm_vld), 36'd1);
    check("clean_stale_drop", 36'(stale), 36'd0);
    idle(SC - 1);
    check("stale_before_limit", 36'(stale), 36'd0);
    idle(1);
    check("stale_at_limit", 36'(stale), 36'd1);
    check("clean_no_err", 36'(err_pulses), 36'd0);

    // Resync through garbage and a doubled sync byte.
    rx_rdy  = 1'b1;
    rx_data = 8'h13;
    #1 check("clr_rdy_follows", 36'(clr_rdy), 36'd1);
    @(negedge clk);
    send_byte(8'hAA); send_byte(8'hAA); send_byte(8'h55);
    send_payload(12'h7E5, 12'h001, 12'h800);
    idle(2);
    check("resync_err_cnt", 36'(err_cnt), 36'd0);
    check("resync_sb_empty", 36'(sb_q.size()), 36'd0);

    // Bad high nibble aborts and leaves outputs alone.
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h1A);
    check("nibble_err_pulse", 36'(frm_err), 36'd1);
    expect_err(1);
    idle(2);
    check("nibble_err_cnt", 36'(err_cnt), 36'(exp_cnt));
    check("nibble_outs_kept", {batt_v, avg_curr, avg_torque}, {12'h7E5, 12'h001, 12'h800});

    // Back-to-back frames with no idle between them.
    send_frame(12'h000, 12'hFFF, 12'h5A5);
    send_frame(12'h321, 12'h654, 12'h987);
    idle(2);
    check("b2b_outs", {batt_v, avg_curr, avg_torque}, {12'h321, 12'h654, 12'h987});

    // Byte gap of BT idle cycles times out exactly BT edges after the last byte.
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h0A);
    hit = -1;
    for (int i = 1; i <= int'(BT) + 3; i++) begin
      idle(1);
      if (frm_err === 1'b1 && hit < 0) hit = i;
    end
    expect_err(1);
    check("gap_timeout_cycle", 36'(hit), 36'(BT));

    // A gap of BT-1 idle cycles is tolerated.
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h0A);
    idle(BT - 1);
    send_byte(8'hBC); send_byte(8'h01); send_byte(8'h23); send_byte(8'h0F);
    sb_q.push_back({12'hABC, 12'h123, 12'hFFF});
    exp_frames++;
    send_byte(8'hFF);
    idle(2);
    check("short_gap_err_pulses", 36'(err_pulses), 36'(exp_err));
    check("short_gap_outs", {batt_v, avg_curr, avg_torque}, {12'hABC, 12'h123, 12'hFFF});

    // 300 bad SYNC2 bytes saturate the error counter.
    for (int i = 0; i < 300; i++) begin
      send_byte(8'hAA);
      send_byte(8'h01);
    end
    idle(2);
    expect_err(300);
    check("sat_err_cnt", 36'(err_cnt), 36'(exp_cnt));
    check("sat_err_pulses", 36'(err_pulses), 36'(exp_err));
    check("frames_seen", 36'(vld_pulses), 36'(exp_frames));

    // Reset mid-frame discards everything.
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h0A);
    rx_rdy = 1'b0;
    rst_n  = 1'b0;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
    send_frame(12'h456, 12'h0F0, 12'h00F);
    idle(2);
    check("post_rst_outs", {batt_v, avg_curr, avg_torque}, {12'h456, 12'h0F0, 12'h00F});
    check("post_rst_err_cnt", 36'(err_cnt), 36'(exp_cnt));
    check("final_sb_empty", 36'(sb_q.size()), 36'd0);
    check("final_frames", 36'(vld_pulses), 36'(exp_frames));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
